// File: rtl/dct1d_pipe.sv
`default_nettype none
// ============================================================================
// dct1d_pipe : 3-stage pipelined 8-point 1-D DCT-II with fixed-point
//              coefficients, valid/ready flow control, rounding/saturation
//              and optional lower-part-OR approximate butterfly adders.
// Revision   : 1.0
// ============================================================================
module dct1d_pipe #(
   parameter int N           = 16,
   parameter int FRAC        = 8,   // supported range 1..15
   parameter int APPROX_BITS = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [8*N-1:0] data_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [8*N-1:0] data_out,
   output logic           sat
);

   localparam int c_w = N + FRAC + 6;
   typedef logic signed [c_w-1:0] acc_t;

   // cos(m*pi/16)/2 in Q16; re-rounded to FRAC bits below
   function automatic int cos_half_q16(input int m);
      case (m)
         1:       return 32138;
         2:       return 30274;
         3:       return 27246;
         4:       return 23170;
         5:       return 18205;
         6:       return 12540;
         7:       return 6393;
         default: return 0;
      endcase
   endfunction

   function automatic int coef(input int m);
      return (cos_half_q16(m) + (1 << (15 - FRAC))) >>> (16 - FRAC);
   endfunction

   localparam acc_t c_k1       = acc_t'(coef(1));
   localparam acc_t c_k2       = acc_t'(coef(2));
   localparam acc_t c_k3       = acc_t'(coef(3));
   localparam acc_t c_k4       = acc_t'(coef(4));
   localparam acc_t c_k5       = acc_t'(coef(5));
   localparam acc_t c_k6       = acc_t'(coef(6));
   localparam acc_t c_k7       = acc_t'(coef(7));
   localparam acc_t c_low_mask = acc_t'((64'd1 << APPROX_BITS) - 64'd1);
   localparam acc_t c_round    = acc_t'(64'd1 << (FRAC - 1));
   localparam acc_t c_max      = acc_t'((64'd1 << (N - 1)) - 64'd1);
   localparam acc_t c_min      = ~c_max;

   // Low part is OR'ed with no carry out; a zero mask degenerates to an exact add.
   function automatic acc_t badd(input acc_t a, input acc_t b);
      acc_t hi;
      hi = (a & ~c_low_mask) + (b & ~c_low_mask);
      return hi | ((a | b) & c_low_mask);
   endfunction

   function automatic acc_t bsub(input acc_t a, input acc_t b);
      return badd(a, -b);
   endfunction

   logic w_advance;
   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance;

   acc_t w_x [8];
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_x[i] = acc_t'($signed(data_in[(7-i)*N +: N]));
      end
   end

   // S1: first even/odd butterfly
   logic r_v1;
   acc_t r_a [4];
   acc_t r_b [4];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_a[i] <= '0;
            r_b[i] <= '0;
         end
      end else if (w_advance) begin
         r_v1 <= in_valid;
         if (in_valid) begin
            for (int i = 0; i < 4; i++) begin
               r_a[i] <= badd(w_x[i], w_x[7-i]);
               r_b[i] <= bsub(w_x[i], w_x[7-i]);
            end
         end
      end
   end

   // S2: second even butterfly; odd products folded into two partial sums per output
   logic r_v2;
   acc_t r_e [4];
   acc_t r_p [4];
   acc_t r_q [4];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2 <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_e[i] <= '0;
            r_p[i] <= '0;
            r_q[i] <= '0;
         end
      end else if (w_advance) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_e[0] <= badd(r_a[0], r_a[3]);
            r_e[1] <= badd(r_a[1], r_a[2]);
            r_e[2] <= bsub(r_a[1], r_a[2]);
            r_e[3] <= bsub(r_a[0], r_a[3]);
            r_p[0] <= badd(c_k1 * r_b[0], c_k3 * r_b[1]);
            r_q[0] <= badd(c_k5 * r_b[2], c_k7 * r_b[3]);
            r_p[1] <= bsub(c_k3 * r_b[0], c_k7 * r_b[1]);
            r_q[1] <= badd(c_k1 * r_b[2], c_k5 * r_b[3]);
            r_p[2] <= bsub(c_k5 * r_b[0], c_k1 * r_b[1]);
            r_q[2] <= badd(c_k7 * r_b[2], c_k3 * r_b[3]);
            r_p[3] <= bsub(c_k7 * r_b[0], c_k5 * r_b[1]);
            r_q[3] <= bsub(c_k3 * r_b[2], c_k1 * r_b[3]);
         end
      end
   end

   // S3: final add/sub, round-half-up, clamp to N bits
   acc_t           w_acc [8];
   acc_t           w_scl [8];
   logic [8*N-1:0] w_y;
   logic           w_sat;
   always_comb begin
      w_acc[0] = c_k4 * badd(r_e[0], r_e[1]);
      w_acc[4] = c_k4 * bsub(r_e[0], r_e[1]);
      w_acc[2] = badd(c_k2 * r_e[3], c_k6 * r_e[2]);
      w_acc[6] = bsub(c_k6 * r_e[3], c_k2 * r_e[2]);
      w_acc[1] = badd(r_p[0], r_q[0]);
      w_acc[3] = bsub(r_p[1], r_q[1]);
      w_acc[5] = badd(r_p[2], r_q[2]);
      w_acc[7] = badd(r_p[3], r_q[3]);
      w_y      = '0;
      w_sat    = 1'b0;
      for (int k = 0; k < 8; k++) begin
         w_scl[k] = (w_acc[k] + c_round) >>> FRAC;
         if (w_scl[k] > c_max) begin
            w_y[(7-k)*N +: N] = c_max[N-1:0];
            w_sat             = 1'b1;
         end else if (w_scl[k] < c_min) begin
            w_y[(7-k)*N +: N] = c_min[N-1:0];
            w_sat             = 1'b1;
         end else begin
            w_y[(7-k)*N +: N] = w_scl[k][N-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         data_out  <= '0;
         sat       <= 1'b0;
      end else if (w_advance) begin
         out_valid <= r_v2;
         if (r_v2) begin
            data_out <= w_y;
            sat      <= w_sat;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dct1d_pipe.sv
`default_nettype none
// ============================================================================
// tb_dct1d_pipe : directed self-checking bench for dct1d_pipe, exact instance
//                 plus an APPROX_BITS=4 instance sharing the same stimulus.
// Revision      : 1.0
// ============================================================================
module tb_dct1d_pipe;

   localparam int N = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           out_ready;
   logic [8*N-1:0] data_in;
   logic           in_ready;
   logic           out_valid;
   logic [8*N-1:0] data_out;
   logic           sat;
   logic           ax_in_ready;
   logic           ax_out_valid;
   logic [8*N-1:0] ax_data_out;
   logic           ax_sat;

   int n_cmp  = 0;
   int n_fail = 0;
   int xin [8];
   int ex  [8];
   int exa [8];
   int sent;
   int got;

   always #5 clk = ~clk;

   dct1d_pipe #(.N(N), .FRAC(8), .APPROX_BITS(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .sat       (sat)
   );

   dct1d_pipe #(.N(N), .FRAC(8), .APPROX_BITS(4)) dut_ax (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ax_in_ready),
      .data_in   (data_in),
      .out_valid (ax_out_valid),
      .out_ready (out_ready),
      .data_out  (ax_data_out),
      .sat       (ax_sat)
   );

   function automatic logic signed [31:0] elem(input logic [8*N-1:0] bus, input int k);
      logic signed [N-1:0] e;
      e = bus[(7-k)*N +: N];
      return e;
   endfunction

   function automatic logic [8*N-1:0] pack(input int x [8]);
      logic [8*N-1:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v[(7-i)*N +: N] = x[i][N-1:0];
      return v;
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Send xin alone through an idle pipe and check latency, ex[] and optionally exa[].
   task automatic run_vec(input string tag, input int exp_sat, input bit check_ax,
                          input int exa_sat);
      int lat;
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = pack(xin);
      lat      = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 8);
      chk({tag, " latency"}, lat, 3);
      for (int k = 0; k < 8; k++)
         chk($sformatf("%s X%0d", tag, k), elem(data_out, k), ex[k]);
      chk({tag, " sat"}, sat, exp_sat);
      if (check_ax) begin
         chk({tag, " ax out_valid"}, ax_out_valid, 1);
         for (int k = 0; k < 8; k++)
            chk($sformatf("%s ax X%0d", tag, k), elem(ax_data_out, k), exa[k]);
         chk({tag, " ax sat"}, ax_sat, exa_sat);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      data_in   = '0;
      repeat (2) @(negedge clk);
      chk("reset out_valid", out_valid, 0);
      chk("reset data_out or-reduce", |data_out, 0);
      chk("reset sat", sat, 0);
      chk("reset ax out_valid", ax_out_valid, 0);
      rst_n = 1'b1;
      #1;
      chk("idle in_ready", in_ready, 1);
      chk("idle ax in_ready", ax_in_ready, 1);

      xin = '{256, 0, 0, 0, 0, 0, 0, 0};
      ex  = '{91, 126, 118, 106, 91, 71, 49, 25};
      exa = '{91, 126, 118, 106, 91, 71, 49, 25};
      run_vec("impulse x0", 0, 1'b1, 0);

      xin = '{0, 0, 0, 256, 0, 0, 0, 0};
      ex  = '{91, 25, -118, -71, 91, 106, -49, -126};
      run_vec("impulse x3", 0, 1'b0, 0);

      xin = '{100, 100, 100, 100, 100, 100, 100, 100};
      ex  = '{284, 0, 0, 0, 0, 0, 0, 0};
      run_vec("dc 100", 0, 1'b0, 0);

      xin = '{100, -100, 100, -100, 100, -100, 100, -100};
      ex  = '{0, 52, 0, 59, 0, 91, 0, 256};
      run_vec("alternating", 0, 1'b0, 0);

      // Only the first butterfly sees two non-zero operands, so the OR-low effect is isolated.
      xin = '{100, 0, 0, 0, 0, 0, 0, 100};
      ex  = '{71, 0, 92, 0, 71, 0, 38, 0};
      exa = '{70, -2, 90, -2, 70, -1, 38, 0};
      run_vec("pair x0 x7", 0, 1'b1, 0);

      xin = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
      ex  = '{32767, 0, 0, 0, 0, 0, 0, 0};
      run_vec("all max", 1, 1'b0, 0);

      xin = '{0, 0, 0, 0, 0, 0, 0, 0};
      ex  = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_vec("all zero", 0, 1'b0, 0);

      xin = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
      ex  = '{-32768, 0, 0, 0, 0, 0, 0, 0};
      run_vec("all min", 1, 1'b0, 0);

      // Back-pressure: five impulses streamed, output stalled for 4 cycles.
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 24 && got < 5; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 3 && cyc <= 6);
         in_valid  = (sent < 5);
         xin       = '{256 * (sent + 1), 0, 0, 0, 0, 0, 0, 0};
         data_in   = pack(xin);
         #1;
         if (out_valid && out_ready) begin
            chk($sformatf("bp vec%0d X0", got + 1), elem(data_out, 0), 91 * (got + 1));
            chk($sformatf("bp vec%0d X7", got + 1), elem(data_out, 7), 25 * (got + 1));
            got++;
         end else if (out_valid) begin
            chk($sformatf("bp stall cyc%0d in_ready", cyc), in_ready, 0);
            chk($sformatf("bp stall cyc%0d X0", cyc), elem(data_out, 0), 91 * (got + 1));
         end
         if (in_valid && in_ready) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp vectors delivered", got, 5);
      chk("bp vectors accepted", sent, 5);
      @(negedge clk);
      chk("bp drained out_valid", out_valid, 0);

      // Reset with three vectors in flight.
      xin = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         in_valid = 1'b1;
         data_in  = pack(xin);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("inflight out_valid", out_valid, 1);
      chk("inflight sat", sat, 1);
      rst_n = 1'b0;
      #1;
      chk("async reset out_valid", out_valid, 0);
      chk("async reset sat", sat, 0);
      chk("async reset data_out or-reduce", |data_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk($sformatf("post-reset empty cyc%0d", j), out_valid, 0);
      end

      xin = '{256, 0, 0, 0, 0, 0, 0, 0};
      ex  = '{91, 126, 118, 106, 91, 71, 49, 25};
      exa = '{91, 126, 118, 106, 91, 71, 49, 25};
      run_vec("post-reset impulse", 0, 1'b1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dct1d_pipe.md
Name: dct1d_pipe

Overview:
- Pipelined, parametrised 8-point 1-D DCT-II. Successor to the combinational butterfly DCT in the approximate-adder study.
- Uses integer fixed-point coefficients instead of real constants.
- Has a valid/ready handshake on both sides, a configurable approximate-adder low part, rounding and saturation.
- Sits between the row/column transpose buffer and the quantiser in the 2-D DCT datapath.

Parameters:
- N, 16, signed sample width of each input and output element.
- FRAC, 8, fractional bits of the coefficients; c_m = round(cos(m*pi/16)/2 * 2^FRAC).
- APPROX_BITS, 0, low bits of every butterfly add/sub computed approximately; 0 means exact. Legal range 0..N/2.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  data_in holds a valid 8-sample vector
- in_ready  output  1  block accepts data_in this cycle
- data_in  input  8*N  samples x0..x7, signed; x0 in bits [8N-1:7N], x7 in bits [N-1:0]
- out_valid  output  1  data_out holds a valid result
- out_ready  input  1  downstream accepts data_out this cycle
- data_out  output  8*N  coefficients X0..X7, signed; X0 in the MSB slot
- sat  output  1  at least one element of the current data_out was saturated

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; all logic is clocked on the rising edge of clk.
- Reset values: out_valid=0, data_out=0, sat=0, all stage valids=0. in_ready is 1 while reset is deasserted and the pipe is empty.
- Coefficients at FRAC=8: c1=126, c2=118, c3=106, c4=91, c5=71, c6=49, c7=25.
- Stage S1: even/odd butterfly. Sums and differences of (x0,x7), (x1,x6), (x2,x5), (x3,x4).
- Stage S2, odd path: odd outputs multiplied by c1/c3/c5/c7 and paired add/sub.
- Stage S2, even path: second even butterfly.
- Stage S3: final add/sub. X2 and X6 formed from c2/c6 products; X0 and X4 multiplied by c4. Then output scaling.
- Internal width: full precision, N+4+FRAC bits minimum; no internal truncation or wrap.
- Output scaling: X = (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift. Clamp to [-2^(N-1), 2^(N-1)-1].
- sat: set to 1 with the result when any of the 8 elements is clamped.
- Exact mode (APPROX_BITS=0): X_k equals the scaled, rounded, saturated value of sum over n of x_n*C_k(n). C_k(n) is ±c_m, obtained from cos((2n+1)k*pi/16) folded to the first quadrant (C_0(n)=c4).
- Approximate mode (APPROX_BITS>0):
  - Each butterfly add A+B uses a lower-part OR for bits below APPROX_BITS (A|B), with no carry into the upper part.
  - Subtract A-B is A+(-B) with -B computed exactly.
  - Multiplications are always exact.
- Latency: 3 cycles from handshake acceptance (in_valid & in_ready) to out_valid=1, with no stall.
- Throughput: 1 vector per cycle.
- Flow control: advance = !out_valid | out_ready; in_ready = advance.
  - When advance=0, every stage register and data_out hold their value.
  - Bubbles propagate as invalid stages; they are not collapsed.
- data_out and sat are stable while out_valid=1 and out_ready=0.
- Simultaneous in accept and out drain in the same cycle is legal; the pipe shifts by one.
- in_valid=0 with advance=1: a bubble enters S1. out_valid falls when the bubble reaches the output.
- Reset mid-operation: all in-flight vectors are discarded. out_valid drops immediately on rst_n=0, with no waiting for a clock edge.

Test Plan:
- Impulse x0=256, rest 0, N=16, FRAC=8, out_ready=1 -> 3 cycles later X0..X7 = 91,126,118,106,91,71,49,25; sat=0.
- DC input, all x=100 -> X0=284 (72800/256 rounded), X1..X7=0, sat=0.
- Alternating x_n=(-1)^n*100 -> X7=256, X1=52, X0=X2=X4=X6=0.
- All x=32767 -> X0=32767, sat=1; the next vector (all 0) gives all 0 and sat=0.
- Back-pressure:
  - Stimulus: stream 5 vectors back-to-back, out_ready low for 4 cycles in the middle.
  - Required: in_ready low during the stall, no vector lost or duplicated, data_out constant while stalled, order preserved.
- Reset and approximate mode:
  - Assert rst_n=0 with 3 vectors in flight -> out_valid=0 at once; after release, the pipe is empty and the first new vector appears after 3 cycles.
  - APPROX_BITS=4, impulse x0=256 -> results match a bit-accurate model of the lower-part OR adder.
